// File: rtl/spi_dac_rx.sv
// spi_dac_rx: slave-side SPI receiver for the 12-bit DAC link.
// It synchronizes sclk/cs/mosi into the clk domain and rebuilds LSB-first frames.
// Each completed frame is presented on dout, together with a one-cycle done strobe.

module spi_dac_rx #(
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    output logic [WIDTH-1:0] dout,
    output logic             done,
    output logic             err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_UNARMED,
        S_IDLE,
        S_RECV,
        S_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclkSync;
    logic [SYNC_STAGES-1:0] r_csSync;
    logic [SYNC_STAGES-1:0] r_mosiSync;
    logic [SYNC_STAGES-1:0] r_syncValid;
    logic                   r_sclkPrev;
    logic                   r_csPrev;

    state_t                 r_state;
    logic [CW-1:0]          r_count;
    logic [WIDTH-1:0]       r_shift;

    logic                   w_sclk;
    logic                   w_cs;
    logic                   w_mosi;
    logic                   w_sclkFall;
    logic                   w_csFall;
    logic                   w_csRise;
    logic                   w_lastBit;
    logic                   w_bitRoom;
    logic [IW-1:0]          w_bitIdx;
    logic [WIDTH-1:0]       w_shiftNext;

    assign w_sclk     = r_sclkSync[SYNC_STAGES-1];
    assign w_cs       = r_csSync[SYNC_STAGES-1];
    assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
    assign w_sclkFall = r_sclkPrev & ~w_sclk;
    assign w_csFall   = r_csPrev & ~w_cs;
    assign w_csRise   = ~r_csPrev & w_cs;
    assign w_bitRoom  = (r_count < CW'(WIDTH));
    assign w_lastBit  = (r_count == CW'(WIDTH - 1));
    assign w_bitIdx   = r_count[IW-1:0];

    // Synchronizer chains plus edge-history flops; r_syncValid marks when the cs chain holds real samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclkSync  <= '0;
            r_csSync    <= '1;
            r_mosiSync  <= '0;
            r_syncValid <= '0;
            r_sclkPrev  <= 1'b0;
            r_csPrev    <= 1'b1;
        end else begin
            r_sclkSync  <= {r_sclkSync[SYNC_STAGES-2:0], sclk};
            r_csSync    <= {r_csSync[SYNC_STAGES-2:0], cs};
            r_mosiSync  <= {r_mosiSync[SYNC_STAGES-2:0], mosi};
            r_syncValid <= {r_syncValid[SYNC_STAGES-2:0], 1'b1};
            r_sclkPrev  <= w_sclk;
            r_csPrev    <= w_cs;
        end
    end

    // Shift register contents as they will look once the current bit has been stored.
    always_comb begin
        w_shiftNext = r_shift;
        if (w_bitRoom) begin
            w_shiftNext[w_bitIdx] = w_mosi;
        end
    end

    // Frame FSM with registered dout/done/err/busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_UNARMED;
            r_count <= '0;
            r_shift <= '0;
            dout    <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                S_UNARMED: begin
                    if (r_syncValid[SYNC_STAGES-1] && w_cs) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (w_csFall) begin
                        r_count <= '0;
                        r_shift <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (w_sclkFall && w_bitRoom) begin
                        r_shift <= w_shiftNext;
                        r_count <= r_count + CW'(1);
                        if (w_lastBit) begin
                            dout <= w_shiftNext;
                            done <= 1'b1;
                            if (w_csRise) begin
                                busy    <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_DONE;
                            end
                        end else if (w_csRise) begin
                            err     <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else if (w_csRise) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (w_csRise) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_UNARMED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_dac_rx.sv
// tb_spi_dac_rx: table-driven frames plus hand-written reset and corner sequences for spi_dac_rx.
// Expected words are queued when a frame is driven, and they are popped when done strobes.

module tb_spi_dac_rx;

    localparam int WIDTH = 12;
    localparam int SYNC  = 2;
    localparam int HALF  = 51;
    localparam int GAP   = SYNC + 2;
    localparam int LAT   = SYNC + 1;
    localparam int NVEC  = 8;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               nbits;
        bit               expDone;
        bit               expErr;
        logic [WIDTH-1:0] expDout;
        bit               coincide;
    } vec_t;

    logic             clk  = 1'b0;
    logic             rst  = 1'b0;
    logic             sclk = 1'b0;
    logic             cs   = 1'b1;
    logic             mosi = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             done;
    logic             err;
    logic             busy;

    int               cycle           = 0;
    int               lastFallCycle   = 0;
    int               lastCsRiseCycle = 0;
    int               doneSeen        = 0;
    int               errSeen         = 0;
    int               expErrPending   = 0;
    int               checkCount      = 0;
    int               passCount       = 0;
    int               failCount       = 0;
    logic [WIDTH-1:0] expQ[$];
    vec_t             vecs[NVEC];

    spi_dac_rx #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sclk (sclk),
        .cs   (cs),
        .mosi (mosi),
        .dout (dout),
        .done (done),
        .err  (err),
        .busy (busy)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Rising-edge counter used to measure strobe latency.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, actual, expected, cycle);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendBits(input logic [WIDTH-1:0] data, input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            sclk = 1'b1;
            mosi = (i < WIDTH) ? data[i] : 1'($urandom_range(0, 1));
            waitCycles(HALF);
            sclk = 1'b0;
            lastFallCycle = cycle;
            waitCycles(HALF);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] data, input int nbits, input bit pushExp, input bit coincide);
        if (pushExp) expQ.push_back(data);
        cs = 1'b0;
        waitCycles(HALF);
        checkOutput("busyInFrame", {31'd0, busy}, 32'd1);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            mosi = (i < WIDTH) ? data[i] : 1'($urandom_range(0, 1));
            waitCycles(HALF);
            sclk = 1'b0;
            lastFallCycle = cycle;
            if (coincide && (i == nbits - 1)) begin
                cs = 1'b1;
                lastCsRiseCycle = cycle;
            end
            waitCycles(HALF);
        end
        if (!coincide) begin
            cs = 1'b1;
            lastCsRiseCycle = cycle;
        end
        waitCycles(GAP);
    endtask

    // Output monitor: pops the scoreboard on done and checks strobe latency.
    always @(negedge clk) begin
        if (rst) begin
            if (done) begin
                doneSeen++;
                if (expQ.size() == 0) begin
                    checkOutput("doneUnexpected", 32'd1, 32'd0);
                end else begin
                    checkOutput("doneDout", 32'(dout), 32'(expQ.pop_front()));
                    checkOutput("doneLatency", 32'(cycle - lastFallCycle), 32'(LAT));
                end
            end
            if (err) begin
                errSeen++;
                if (expErrPending == 0) begin
                    checkOutput("errUnexpected", 32'd1, 32'd0);
                end else begin
                    expErrPending--;
                    checkOutput("errLatency", 32'(cycle - lastCsRiseCycle), 32'(LAT));
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        int d0;
        int e0;

        vecs[0] = '{12'h001, 12, 1'b1, 1'b0, 12'h001, 1'b0};
        vecs[1] = '{12'hFFF, 12, 1'b1, 1'b0, 12'hFFF, 1'b0};
        vecs[2] = '{12'hA5C, 12, 1'b1, 1'b0, 12'hA5C, 1'b0};
        vecs[3] = '{12'h3C3,  7, 1'b0, 1'b1, 12'hA5C, 1'b0};
        vecs[4] = '{12'h123, 12, 1'b1, 1'b0, 12'h123, 1'b0};
        vecs[5] = '{12'h5A5, 14, 1'b1, 1'b0, 12'h5A5, 1'b0};
        vecs[6] = '{12'h800, 12, 1'b1, 1'b0, 12'h800, 1'b0};
        vecs[7] = '{12'h7FE, 12, 1'b1, 1'b0, 12'h7FE, 1'b1};

        waitCycles(3);
        checkOutput("resetDout", 32'(dout), 32'd0);
        checkOutput("resetDone", {31'd0, done}, 32'd0);
        checkOutput("resetErr",  {31'd0, err},  32'd0);
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        waitCycles(GAP + 4);

        for (int i = 0; i < NVEC; i++) begin
            d0 = doneSeen;
            e0 = errSeen;
            if (vecs[i].expErr) expErrPending++;
            applyStimulus(vecs[i].data, vecs[i].nbits, vecs[i].expDone, vecs[i].coincide);
            checkOutput("vecDoneCount", 32'(doneSeen - d0), {31'd0, vecs[i].expDone});
            checkOutput("vecErrCount",  32'(errSeen - e0),  {31'd0, vecs[i].expErr});
            checkOutput("vecDout",      32'(dout),          32'(vecs[i].expDout));
            checkOutput("vecBusyAfter", {31'd0, busy},      32'd0);
        end

        $display("[TB] reset mid-frame, released with cs high");
        cs = 1'b0;
        waitCycles(HALF);
        sendBits(12'h555, 0, 6);
        rst = 1'b0;
        #1;
        checkOutput("rstADout", 32'(dout), 32'd0);
        checkOutput("rstADone", {31'd0, done}, 32'd0);
        checkOutput("rstAErr",  {31'd0, err},  32'd0);
        checkOutput("rstABusy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        cs = 1'b1;
        waitCycles(5);
        rst = 1'b1;
        waitCycles(GAP + 4);
        applyStimulus(12'h3C3, 12, 1'b1, 1'b0);
        checkOutput("rstAFrameDout", 32'(dout), 32'h3C3);

        $display("[TB] reset mid-frame, released with cs low");
        cs = 1'b0;
        waitCycles(HALF);
        sendBits(12'hAAA, 0, 6);
        rst = 1'b0;
        #1;
        checkOutput("rstBDout", 32'(dout), 32'd0);
        checkOutput("rstBBusy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        waitCycles(5);
        rst = 1'b1;
        d0 = doneSeen;
        e0 = errSeen;
        sendBits(12'hAAA, 6, 6);
        checkOutput("rstBBusyMid", {31'd0, busy}, 32'd0);
        cs = 1'b1;
        lastCsRiseCycle = cycle;
        waitCycles(GAP + 10);
        checkOutput("rstBNoDone", 32'(doneSeen - d0), 32'd0);
        checkOutput("rstBNoErr",  32'(errSeen - e0),  32'd0);
        checkOutput("rstBDoutHeld", 32'(dout), 32'd0);
        applyStimulus(12'h0F0, 12, 1'b1, 1'b0);
        checkOutput("rstBFrameDout", 32'(dout), 32'h0F0);

        $display("[TB] sclk toggling with cs high");
        d0 = doneSeen;
        e0 = errSeen;
        for (int i = 0; i < 20; i++) begin
            sclk = 1'b1;
            mosi = 1'($urandom_range(0, 1));
            waitCycles(HALF);
            sclk = 1'b0;
            waitCycles(HALF);
        end
        checkOutput("idleNoDone", 32'(doneSeen - d0), 32'd0);
        checkOutput("idleNoErr",  32'(errSeen - e0),  32'd0);
        checkOutput("idleBusy",   {31'd0, busy},      32'd0);
        checkOutput("idleDout",   32'(dout),          32'h0F0);

        applyStimulus(12'hA5C, 12, 1'b1, 1'b0);
        checkOutput("finalDout", 32'(dout), 32'hA5C);
        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        checkOutput("errPendingZero", 32'(expErrPending), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
